// File: rtl/enc_event_fifo.sv
// enc_event_fifo: turns encoder index/valid changes into events queued in a small FIFO; optional drop counter via ENC_EVT_DROP_CNT_EN
module enc_event_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IDX_W-1:0]         enc_idx,
    input  logic                     enc_valid,
    output logic [IDX_W-1:0]         evt_idx,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
`ifdef ENC_EVT_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    logic [IDX_W-1:0] mem_q [DEPTH];
    logic             prev_valid_q, prev_valid_d;
    logic [IDX_W-1:0] prev_idx_q, prev_idx_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             evt, pop, push, drop;
`ifdef ENC_EVT_DROP_CNT_EN
    logic [7:0]       drop_cnt_q, drop_cnt_d;
`endif

    assign evt_idx   = mem_q[rd_ptr_q];
    assign evt_valid = count_q != '0;
    assign full      = count_q == (PW+1)'(DEPTH);
    assign count     = count_q;
    assign overflow  = overflow_q;
`ifdef ENC_EVT_DROP_CNT_EN
    assign drop_cnt  = drop_cnt_q;
`endif

    // Event detection, handshake decisions and next-state for pointers and occupancy
    always_comb begin
        evt          = enc_valid && (!prev_valid_q || enc_idx != prev_idx_q);
        pop          = evt_valid && evt_ready;
        push         = evt && (!full || pop);
        drop         = evt && full && !pop;
        prev_valid_d = enc_valid;
        prev_idx_d   = enc_idx;
        rd_ptr_d     = pop ? PW'(rd_ptr_q + 1'b1) : rd_ptr_q;
        wr_ptr_d     = push ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        count_d      = (push && !pop) ? count_q + 1'b1 :
                       (pop && !push) ? count_q - 1'b1 : count_q;
        overflow_d   = drop;
`ifdef ENC_EVT_DROP_CNT_EN
        drop_cnt_d   = (drop && drop_cnt_q != 8'hff) ? drop_cnt_q + 8'd1 : drop_cnt_q;
`endif
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_valid_q <= 1'b0;
            prev_idx_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
`ifdef ENC_EVT_DROP_CNT_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            prev_valid_q <= prev_valid_d;
            prev_idx_q   <= prev_idx_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
`ifdef ENC_EVT_DROP_CNT_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    // Storage is not reset; only written on an accepted push
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= enc_idx;
    end
endmodule

// File: tb/tb_enc_event_fifo.sv
// tb_enc_event_fifo: scoreboard bench for enc_event_fifo
module tb_enc_event_fifo;
    localparam int DEPTH = 4;
    localparam int IDX_W = 3;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_valid;
    logic             evt_ready;
    logic [2:0]       count;
    logic             full;
    logic             overflow;
`ifdef ENC_EVT_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif
    int n_chk = 0;
    int n_err = 0;
    int mq[$];
    int m_pv, m_pidx, m_ovf, m_drops, ovf_seen, last_pop;

    enc_event_fifo #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .enc_idx(enc_idx), .enc_valid(enc_valid),
        .evt_idx(evt_idx), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .count(count), .full(full), .overflow(overflow)
`ifdef ENC_EVT_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic post_checks();
        chk("count", int'(count), mq.size());
        chk("evt_valid", int'(evt_valid), int'(mq.size() != 0));
        chk("full", int'(full), int'(mq.size() == DEPTH));
        chk("overflow", int'(overflow), m_ovf);
        if (mq.size() != 0) chk("head", int'(evt_idx), mq[0]);
`ifdef ENC_EVT_DROP_CNT_EN
        chk("drop_cnt", int'(drop_cnt), m_drops);
`endif
    endtask

    task automatic do_reset(input int n, input int idx, input int v);
        rst_n = 1'b0; enc_idx = IDX_W'(idx); enc_valid = v[0]; evt_ready = 1'b0;
        mq.delete(); m_pv = 0; m_pidx = 0; m_ovf = 0; m_drops = 0;
        repeat (n) begin
            @(posedge clk); @(negedge clk);
            chk("rst_count", int'(count), 0);
            chk("rst_evt_valid", int'(evt_valid), 0);
            chk("rst_overflow", int'(overflow), 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic step(input int idx, input int v, input int r);
        bit ev;
        enc_idx = IDX_W'(idx); enc_valid = v[0]; evt_ready = r[0];
        ev = v != 0 && (m_pv == 0 || idx != m_pidx);
        if (r != 0 && mq.size() != 0) begin
            last_pop = mq.pop_front();
            chk("pop_idx", int'(evt_idx), last_pop);
        end
        m_ovf = 0;
        if (ev) begin
            if (mq.size() < DEPTH) mq.push_back(idx);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_pv = v; m_pidx = idx;
        @(posedge clk); @(negedge clk);
        ovf_seen += int'(overflow);
        post_checks();
    endtask

    initial begin
        @(negedge clk);
        do_reset(2, 5, 1);
        step(5, 1, 0);
        chk("rel_idx", int'(evt_idx), 5);
        chk("rel_count", int'(count), 1);
        step(5, 1, 0);
        chk("rel_one_event", int'(count), 1);
        step(5, 1, 1);
        step(0, 0, 0);
        foreach (mq[i]) chk("empty_model", mq[i], -1);
        begin
            int seq[6] = '{3, 3, 3, 1, 1, 6};
            foreach (seq[i]) step(seq[i], 1, 0);
        end
        chk("chg_count", int'(count), 3);
        step(6, 1, 1); chk("drain0", last_pop, 3);
        step(6, 1, 1); chk("drain1", last_pop, 1);
        step(6, 1, 1); chk("drain2", last_pop, 6);
        step(6, 0, 0);
        step(2, 1, 0); step(2, 0, 0); step(2, 1, 0);
        chk("tog_count", int'(count), 2);
        step(2, 0, 1); chk("tog0", last_pop, 2);
        step(2, 0, 1); chk("tog1", last_pop, 2);
        ovf_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(i, 1, 0);
            if (i == 3) chk("full_after4", int'(full), 1);
        end
        chk("ovf_pulses", ovf_seen, 2);
`ifdef ENC_EVT_DROP_CNT_EN
        chk("drop_cnt2", int'(drop_cnt), 2);
`endif
        step(7, 1, 1);
        chk("pp_count", int'(count), 4);
        chk("pp_ovf", int'(overflow), 0);
        for (int i = 0; i < 4; i++) step(7, 0, 1);
        chk("pp_last", last_pop, 7);
        for (int i = 0; i < 20; i++) step(i % 8, 1, 1);
        step(0, 0, 1);
        chk("wrap_count", int'(count), 0);
        do_reset(1, 4, 1);
        step(4, 1, 0);
        chk("mid_rst_count", int'(count), 1);
`ifdef ENC_EVT_DROP_CNT_EN
        for (int i = 0; i < 304; i++) step(i % 2, 1, 0);
        chk("drop_sat", int'(drop_cnt), 255);
`endif
        do_reset(1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
